// File: rtl/agc_pkg.sv
// Shared types and default tuning constants for the auto gain control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_EVAL    = 2'd2,
    ST_SETTLE  = 2'd3
  } agc_state_t;

  typedef logic [1:0]  gain_t;
  typedef logic [11:0] sample_t;

  localparam gain_t GAIN_MIN = 2'd0;
  localparam gain_t GAIN_MAX = 2'd3;

  localparam int DEF_WINDOW_LEN     = 256;
  localparam int DEF_SETTLE_LEN     = 16;
  localparam int DEF_STABLE_WINDOWS = 4;

  // Thresholds as fractions of the 12-bit full scale: 25%, 75%, 90%.
  localparam sample_t DEF_LOW_TH  = 12'd1024;
  localparam sample_t DEF_HIGH_TH = 12'd3072;
  localparam sample_t DEF_OVL_TH  = 12'd3686;

endpackage

// File: rtl/agc_peak_detector.sv
// Running maximum of the ADC samples seen since the last clear.
// Latency: peak reflects a sample one cycle after it is presented with en high.
// Backpressure: none; en qualifies each sample, clear takes priority over en.
module agc_peak_detector
  import agc_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    en,
  input  sample_t data,
  output sample_t peak
);

  // Hold the largest enabled sample; clear restarts the window from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (clear) begin
      peak <= '0;
    end else if (en && (data > peak)) begin
      peak <= data;
    end
  end

endmodule

// File: rtl/auto_gain_control.sv
// Windowed-peak ADC gain control; optional fast overload path under AGC_OVERLOAD_FAST_EN.
// Latency: gain_ctrl/stable update on the edge after EVAL (or after an overload sample).
// Backpressure: none; one adc_data sample is consumed every adc_clk cycle.
module auto_gain_control
  import agc_pkg::*;
#(
  parameter int      WINDOW_LEN     = DEF_WINDOW_LEN,
  parameter sample_t LOW_TH         = DEF_LOW_TH,
  parameter sample_t HIGH_TH        = DEF_HIGH_TH,
  parameter sample_t OVL_TH         = DEF_OVL_TH,
  parameter int      SETTLE_LEN     = DEF_SETTLE_LEN,
  parameter int      STABLE_WINDOWS = DEF_STABLE_WINDOWS
) (
  input  logic        adc_clk,
  input  logic        rst_n,
  input  logic [11:0] adc_data,
  output logic [1:0]  gain_ctrl,
  output logic        stable
);

  localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int SET_W = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
  localparam int STB_W = $clog2(STABLE_WINDOWS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_LEN - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_WINDOWS);

`ifdef AGC_OVERLOAD_FAST_EN
  localparam bit OVL_FAST_EN = 1'b1;
`else
  localparam bit OVL_FAST_EN = 1'b0;
`endif

  agc_state_t       state;
  agc_state_t       state_nxt;
  logic [CNT_W-1:0] sample_count;
  logic [SET_W-1:0] settle_count;
  logic [STB_W-1:0] stable_counter;
  logic [STB_W-1:0] stable_cnt_inc;
  sample_t          peak;

  logic in_measure;
  logic window_done;
  logic settle_done;
  logic eval_dec;
  logic eval_inc;
  logic ovl_dec;
  logic peak_clear;
  logic peak_en;
  logic gain_dn;
  logic gain_up;
  logic eval_hold;

  agc_peak_detector u_peak (
    .clk   (adc_clk),
    .rst_n (rst_n),
    .clear (peak_clear),
    .en    (peak_en),
    .data  (adc_data),
    .peak  (peak)
  );

  assign in_measure  = (state == ST_MEASURE);
  assign window_done = in_measure && (sample_count == CNT_LAST);
  assign settle_done = (state == ST_SETTLE) && (settle_count == SET_LAST);

  // Equality with either threshold is in range; increment never fires alongside a decrement.
  assign eval_dec = (state == ST_EVAL) && (peak > HIGH_TH) && (gain_ctrl != GAIN_MIN);
  assign eval_inc = (state == ST_EVAL) && (peak < LOW_TH) && (gain_ctrl != GAIN_MAX) && !eval_dec;

  // Fast overload only acts while measuring; the constant folds away when the feature is off.
  assign ovl_dec  = OVL_FAST_EN && in_measure && (adc_data >= OVL_TH) && (gain_ctrl != GAIN_MIN);

  assign stable_cnt_inc = (stable_counter == STB_MAX) ? stable_counter : stable_counter + 1'b1;

  // State register.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: overload preempts the window; EVAL goes to SETTLE only after a gain step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = ST_MEASURE;
      ST_MEASURE: begin
        if (ovl_dec)          state_nxt = ST_SETTLE;
        else if (window_done) state_nxt = ST_EVAL;
      end
      ST_EVAL:    state_nxt = (eval_dec || eval_inc) ? ST_SETTLE : ST_MEASURE;
      ST_SETTLE:  if (settle_done) state_nxt = ST_MEASURE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: peak accumulates only in MEASURE and is zeroed everywhere else, so each window starts clean.
  always_comb begin
    peak_clear = 1'b1;
    peak_en    = 1'b0;
    gain_dn    = 1'b0;
    gain_up    = 1'b0;
    eval_hold  = 1'b0;
    case (state)
      ST_MEASURE: begin
        peak_clear = 1'b0;
        peak_en    = 1'b1;
        gain_dn    = ovl_dec;
      end
      ST_EVAL: begin
        gain_dn   = eval_dec;
        gain_up   = eval_inc;
        eval_hold = !(eval_dec || eval_inc);
      end
      default: ;
    endcase
  end

  // Window sample counter, restarted whenever MEASURE is (re)entered.
  always_ff @(posedge adc_clk) begin
    if (!rst_n)                        sample_count <= '0;
    else if (!in_measure || window_done) sample_count <= '0;
    else                               sample_count <= sample_count + 1'b1;
  end

  // Settle counter: samples in SETTLE are dropped until it expires.
  always_ff @(posedge adc_clk) begin
    if (!rst_n)                                   settle_count <= '0;
    else if ((state != ST_SETTLE) || settle_done) settle_count <= '0;
    else                                          settle_count <= settle_count + 1'b1;
  end

  // Gain step and stability tracking; decrement has priority so at most one step lands per cycle.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      gain_ctrl      <= GAIN_MIN;
      stable_counter <= '0;
      stable         <= 1'b0;
    end else if (gain_dn) begin
      gain_ctrl      <= gain_ctrl - 2'd1;
      stable_counter <= '0;
      stable         <= 1'b0;
    end else if (gain_up) begin
      gain_ctrl      <= gain_ctrl + 2'd1;
      stable_counter <= '0;
      stable         <= 1'b0;
    end else if (eval_hold) begin
      stable_counter <= stable_cnt_inc;
      stable         <= (stable_cnt_inc == STB_MAX);
    end
  end

endmodule

// File: tb/tb_auto_gain_control.sv
// Directed-plus-random bench for auto_gain_control with a window-level reference model.
// Latency: checks land 1 time unit after the adc_clk edge of interest.
// Backpressure: n/a; one sample is driven every cycle.
module tb_auto_gain_control;

  localparam int WINDOW_LEN     = 256;
  localparam int SETTLE_LEN     = 16;
  localparam int STABLE_WINDOWS = 4;
  localparam int LOW_TH         = 1024;
  localparam int HIGH_TH        = 3072;

  logic        adc_clk = 1'b0;
  logic        rst_n;
  logic [11:0] adc_data;
  logic [1:0]  gain_ctrl;
  logic        stable;

  int checks = 0;
  int errors = 0;
  int gain_m;     // expected gain step
  int stab_m;     // expected count of consecutive unchanged windows (saturating)

  auto_gain_control dut (
    .adc_clk   (adc_clk),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
    .gain_ctrl (gain_ctrl),
    .stable    (stable)
  );

  always #5 adc_clk = ~adc_clk;

  // Present one sample, let the edge consume it, then settle 1 unit past the edge.
  task automatic step(input int d);
    adc_data = 12'(d);
    @(posedge adc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_gain"},   {10'd0, gain_ctrl}, 12'(gain_m));
    chk({tag, "_stable"}, {11'd0, stable},    (stab_m == STABLE_WINDOWS) ? 12'd1 : 12'd0);
  endtask

  // Apply the window decision rules to a measured peak, run the EVAL cycle and any settle period.
  task automatic eval_settle(input int pk, input string tag);
    bit chg;
    chg = 1'b0;
    if (pk > HIGH_TH && gain_m > 0) begin
      gain_m = gain_m - 1;
      chg = 1'b1;
    end else if (pk < LOW_TH && gain_m < 3) begin
      gain_m = gain_m + 1;
      chg = 1'b1;
    end
    if (chg) stab_m = 0;
    else if (stab_m < STABLE_WINDOWS) stab_m = stab_m + 1;
    step(4095);                       // EVAL cycle: sample must not matter
    chk_outputs({tag, "_eval"});
    // Full-scale junk while settling would corrupt the next window if it leaked in.
    if (chg) repeat (SETTLE_LEN) step(4095);
  endtask

  // One full window of samples in [lo,hi], with hi forced at a random position.
  task automatic run_window(input int lo, input int hi, input string tag);
    int pk;
    int fi;
    int v;
    pk = 0;
    fi = $urandom_range(WINDOW_LEN - 1, 0);
    for (int i = 0; i < WINDOW_LEN; i++) begin
      v = (i == fi) ? hi : int'($urandom_range(hi, lo));
      if (v > pk) pk = v;
      step(v);
    end
    chk_outputs({tag, "_pre"});       // last sample taken, decision not yet visible
    eval_settle(pk, tag);
  endtask

  initial begin
    int k;
    int lo;
    int hi;

    rst_n    = 1'b0;
    adc_data = '0;
    gain_m   = 0;
    stab_m   = 0;
    repeat (3) step(0);
    chk_outputs("reset");

    rst_n = 1'b1;
    step(4095);                       // IDLE cycle: sample ignored

    // 200 mV: ramp to max gain, then hold there until stable.
    for (int w = 0; w < 7; w++) run_window(409, 409, "ramp_200mv");

    // 1700 mV while stable at gain 3: one step down, stable drops.
    run_window(3480, 3480, "hi_1700mv");

    // Threshold equality counts as in range.
    run_window(1024, 3072, "eq_high_a");
    run_window(1024, 1024, "eq_low_a");
    run_window(1024, 3072, "eq_high_b");
    run_window(1024, 1024, "eq_low_b");

    // Just past each threshold.
    run_window(2000, 3073, "above_high");
    run_window(0, 1023, "below_low");
    run_window(0, 500, "to_max");

    // Single 1900 mV sample inside a window at gain 3.
    k = $urandom_range(200, 10);
    for (int i = 0; i < k; i++) step(2000);
    step(3890);
`ifdef AGC_OVERLOAD_FAST_EN
    gain_m = gain_m - 1;
    stab_m = 0;
    chk_outputs("ovl_fast");
    repeat (SETTLE_LEN) step(4095);
`else
    chk_outputs("ovl_deferred");
    for (int i = k + 1; i < WINDOW_LEN; i++) step(2000);
    chk_outputs("ovl_pre");
    eval_settle(3890, "ovl");
`endif

    // Reset pulse mid-window at gain 2.
    chk_outputs("before_mid_reset");
    for (int i = 0; i < 100; i++) step($urandom_range(3000, 1100));
    rst_n = 1'b0;
    step(0);
    gain_m = 0;
    stab_m = 0;
    chk_outputs("mid_reset");
    rst_n = 1'b1;
    step(4095);

    // 1100 mV from reset: gain stays 0, stable after the 4th window.
    for (int w = 0; w < 5; w++) run_window(2252, 2252, "mid_1100mv");

    // Random windows kept below the overload level.
    for (int w = 0; w < 10; w++) begin
      hi = $urandom_range(3685, 0);
      lo = $urandom_range(hi, 0);
      run_window(lo, hi, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/auto_gain_control.md
AUTO_GAIN_CONTROL -- requirements
Module: auto_gain_control

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: clock adc_clk, reset rst_n; all state changes on posedge adc_clk.
REQ-002 Parameter WINDOW_LEN, 256, number of samples per peak-measurement window.
REQ-003 Parameter LOW_TH, 12'd1024, window peak below this raises gain (25% full scale).
REQ-004 Parameter HIGH_TH, 12'd3072, window peak above this lowers gain (75% full scale).
REQ-005 Parameter OVL_TH, 12'd3686, instantaneous overload level (90% full scale).
REQ-006 Parameter SETTLE_LEN, 16, samples discarded after any gain change.
REQ-007 Parameter STABLE_WINDOWS, 4, consecutive unchanged windows needed to assert stable.
REQ-008 adc_clk  input  1  sample clock; one valid adc_data sample per cycle.
REQ-009 rst_n  input  1  synchronous active-low reset.
REQ-010 adc_data  input  12  unsigned ADC code, 0..4095 = 0..2000 mV.
REQ-011 gain_ctrl  output  2  registered gain step, 0 = lowest gain, 3 = highest.
REQ-012 stable  output  1  registered; high while gain has been settled STABLE_WINDOWS windows.

Function
REQ-013 SHALL implement FSM states IDLE, MEASURE, EVAL, SETTLE; IDLE lasts one cycle after reset, then MEASURE.
REQ-014 In MEASURE, peak SHALL track max(peak, adc_data) each cycle and sample_count SHALL count 0..WINDOW_LEN-1; peak and sample_count clear on entry to MEASURE.
REQ-015 When sample_count = WINDOW_LEN-1, next state SHALL be EVAL, with the final sample included in peak.
REQ-016 In EVAL (one cycle): peak > HIGH_TH and gain_ctrl > 0 -> decrement; peak < LOW_TH and gain_ctrl < 3 -> increment; otherwise hold; new gain_ctrl visible on the cycle after EVAL.
REQ-017 Equality with LOW_TH or HIGH_TH SHALL count as in range (no change).
REQ-018 After EVAL with a change -> SETTLE; without change -> MEASURE.
REQ-019 SETTLE SHALL ignore adc_data for SETTLE_LEN cycles, then enter MEASURE.
REQ-020 gain_ctrl SHALL saturate at 0 and 3, never wrapping.
REQ-021 stable_counter SHALL increment (saturating at STABLE_WINDOWS) on each EVAL without change and clear on any gain change.
REQ-022 stable SHALL be high exactly when stable_counter = STABLE_WINDOWS; a window held at a saturated limit counts as unchanged.
REQ-023 gain_ctrl SHALL change at most once per cycle; simultaneous overload and EVAL decision: overload wins.

Reset
REQ-024 rst_n low on a clock edge SHALL force gain_ctrl=0, stable=0, peak=0, sample_count=0, stable_counter=0, state=IDLE, including mid-window or mid-settle.

Configuration
REQ-025 Macro AGC_OVERLOAD_FAST_EN defined: in MEASURE, adc_data >= OVL_TH with gain_ctrl > 0 SHALL decrement gain_ctrl on the next edge, clear stable_counter/stable, and enter SETTLE without waiting for window end.
REQ-026 Macro undefined: overload SHALL be handled only through the EVAL rule; OVL_TH unused.

Structure
REQ-027 Shared package agc_pkg SHALL hold the state enum, 2-bit gain typedef, 12-bit sample typedef, and default threshold constants.
REQ-028 Peak tracking SHALL live in sub-module agc_peak_detector (inputs clk, rst_n, clear, en, data; output peak).

Verification
REQ-029 Reset, then 200 mV (code 409) constant -> gain_ctrl steps 0->1->2->3, one step per window plus settle, then holds at 3; stable high after 4 further windows.
REQ-030 1100 mV (code 2252) constant from reset -> gain_ctrl stays 0, stable asserts after the 4th EVAL.
REQ-031 With gain 3 stable, apply 1700 mV (code 3480) -> decrement at next EVAL, stable drops the same cycle gain changes.
REQ-032 Macro defined, gain 3, single sample of 1900 mV (code 3890) -> gain_ctrl=2 on the following cycle, state SETTLE; macro undefined -> no change until EVAL.
REQ-033 Peak exactly 3072 or exactly 1024 at EVAL -> no gain change, stable_counter increments.
REQ-034 rst_n pulsed low mid-window at gain 2 -> next cycle gain_ctrl=0, stable=0, sample_count=0.
